// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the instruction fetch stage: FSM states, HALT opcode
// and the NOP word used to flush the decode input.
package instruction_fetch_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_HALTED = 2'd2
   } fetch_state_t;

   localparam logic [5:0]  HALT_OPCODE = 6'b111111;
   localparam logic [31:0] NOP_WORD    = 32'h0000_0000;

   function automatic logic is_halt(input logic [5:0] opcode);
      return opcode == HALT_OPCODE;
   endfunction

endpackage

// File: rtl/instruction_memory.sv
// Instruction word array: synchronous write port for program load,
// combinational read port addressed by the PC word index.
module instruction_memory #(
   parameter int len       = 32,
   parameter int mem_depth = 256,
   parameter int NB_ADDR   = $clog2(mem_depth)
) (
   input  logic               clk,
   input  logic               wr_en,
   input  logic [NB_ADDR-1:0] wr_addr,
   input  logic [len-1:0]     wr_data,
   input  logic [NB_ADDR-1:0] rd_addr,
   output logic [len-1:0]     rd_data
);

   // No reset: the loaded program must survive a reset of the fetch stage.
   logic [len-1:0] mem [mem_depth];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: PC register, redirect/stall handling, HALT detection
// and the registered instruction/PC+4 pair handed to decode.
module instruction_fetch
   import instruction_fetch_pkg::*;
#(
   parameter int len       = 32,
   parameter int mem_depth = 256,
   parameter int NB_ADDR   = $clog2(mem_depth)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               load_enable,
   input  logic [NB_ADDR-1:0] load_addr,
   input  logic [len-1:0]     load_data,
   input  logic               stall,
   input  logic               flag_branch,
   input  logic [len-1:0]     in_pc_branch_target,
   input  logic               flag_jump,
   input  logic [len-1:0]     in_pc_jump,
   input  logic               flag_jump_register,
   input  logic [len-1:0]     in_pc_register,
   output logic [len-1:0]     out_pc_branch,
   output logic [len-1:0]     out_instruccion,
   output logic [len-1:0]     out_pc,
   output logic               out_halted,
   output fetch_state_t       dbg_state
);

   fetch_state_t   state, state_next;
   logic [len-1:0] pc, pc_next;
   logic [len-1:0] instr_next, pc_branch_next;
   logic [len-1:0] rd_data, pc_plus4, redirect_target;
   logic           redirect;

   instruction_memory #(
      .len       (len),
      .mem_depth (mem_depth),
      .NB_ADDR   (NB_ADDR)
   ) u_mem (
      .clk     (clk),
      .wr_en   (load_enable && (state == ST_IDLE)),
      .wr_addr (load_addr),
      .wr_data (load_data),
      .rd_addr (pc[NB_ADDR+1:2]),
      .rd_data (rd_data)
   );

   assign pc_plus4 = pc + len'(4);
   assign redirect = flag_branch | flag_jump_register | flag_jump;
   assign redirect_target = flag_branch        ? in_pc_branch_target :
                            flag_jump_register ? in_pc_register      :
                                                 in_pc_jump;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state           <= ST_IDLE;
         pc              <= '0;
         out_instruccion <= '0;
         out_pc_branch   <= '0;
      end else begin
         state           <= state_next;
         pc              <= pc_next;
         out_instruccion <= instr_next;
         out_pc_branch   <= pc_branch_next;
      end
   end

   always_comb begin
      state_next     = state;
      pc_next        = pc;
      instr_next     = out_instruccion;
      pc_branch_next = out_pc_branch;
      case (state)
         ST_IDLE: begin
            pc_next        = '0;
            instr_next     = len'(NOP_WORD);
            pc_branch_next = '0;
            if (start) state_next = ST_RUN;
         end
         ST_RUN: begin
            // A redirect overrides both stall and a HALT sitting in the fetch slot.
            if (redirect) begin
               pc_next        = redirect_target;
               instr_next     = len'(NOP_WORD);
               pc_branch_next = '0;
            end else if (!stall) begin
               instr_next     = rd_data;
               pc_branch_next = pc_plus4;
               if (is_halt(rd_data[len-1 -: 6])) state_next = ST_HALTED;
               else                              pc_next    = pc_plus4;
            end
         end
         ST_HALTED: begin
            instr_next = len'(NOP_WORD);
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   assign out_pc     = pc;
   assign out_halted = (state == ST_HALTED);
   assign dbg_state  = state;

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter: len, 32, data/instruction/PC width in bits.
REQ-002 Parameter: mem_depth, 256, instruction memory depth in 32-bit words.
REQ-003 Parameter: NB_ADDR, $clog2(mem_depth), word-index width.
REQ-004 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset (0 = reset asserted).
REQ-006 start  in  1  one-cycle pulse; IDLE -> RUN.
REQ-007 load_enable  in  1  program-load write strobe, honoured only in IDLE.
REQ-008 load_addr  in  NB_ADDR  word index for the program-load write.
REQ-009 load_data  in  len  instruction word for the program-load write.
REQ-010 stall  in  1  hazard stall: hold PC and outputs.
REQ-011 flag_branch  in  1  taken branch resolved downstream; redirect to in_pc_branch_target.
REQ-012 in_pc_branch_target  in  len  branch target byte address.
REQ-013 flag_jump  in  1  J/JAL from decode; redirect to in_pc_jump.
REQ-014 in_pc_jump  in  len  jump target byte address.
REQ-015 flag_jump_register  in  1  JR/JALR from decode; redirect to in_pc_register.
REQ-016 in_pc_register  in  len  register jump target byte address.
REQ-017 out_pc_branch  out  len  registered PC+4 of the fetched instruction (feeds decode in_pc_branch).
REQ-018 out_instruccion  out  len  registered fetched instruction (feeds decode in_instruccion).
REQ-019 out_pc  out  len  current PC register value.
REQ-020 out_halted  out  1  high while in HALTED.

Function
REQ-021 FSM states SHALL be IDLE, RUN, HALTED.
REQ-022 IDLE: PC held at 0; outputs held at 0; load_enable=1 writes load_data to mem[load_addr] at the clock edge; start=1 -> RUN.
REQ-023 RUN, stall=0, no redirect: out_instruccion <= mem[PC[NB_ADDR+1:2]], out_pc_branch <= PC+4, PC <= PC+4 (one-cycle fetch latency).
REQ-024 Next-PC priority SHALL be flag_branch > flag_jump_register > flag_jump > PC+4.
REQ-025 Any redirect SHALL load PC with the selected target and set out_instruccion <= 0 (NOP flush) on the same edge; out_pc_branch <= 0.
REQ-026 stall=1 without redirect: PC, out_instruccion, out_pc_branch hold.
REQ-027 Redirect and stall simultaneous: the redirect SHALL win (PC updated, NOP emitted).
REQ-028 Memory read index SHALL use PC bits [NB_ADDR+1:2]; PC beyond mem_depth wraps modulo mem_depth; PC bits [1:0] ignored.
REQ-029 PC+4 SHALL wrap modulo 2^len with no error flag.
REQ-030 Fetched word with opcode [31:26] = 6'b111111 (HALT): word forwarded to out_instruccion, PC frozen, state -> HALTED on the same edge.
REQ-031 HALTED: out_instruccion <= 0 every cycle, PC held, out_halted=1; exit only via reset.
REQ-032 A redirect arriving in the HALT fetch cycle SHALL take priority and cancel the halt (HALT word flushed).
REQ-033 load_enable outside IDLE SHALL be ignored; start outside IDLE SHALL be ignored.

Reset
REQ-034 reset=0 SHALL immediately force PC=0, out_instruccion=0, out_pc_branch=0, out_halted=0, state=IDLE, independent of clk.
REQ-035 Instruction memory contents SHALL NOT be cleared by reset; reset mid-RUN returns to IDLE with the program intact.

Structure
REQ-036 Shared package SHALL hold HALT opcode constant, NOP word (32'h0), FSM state encodings.
REQ-037 Sub-module instruction_memory SHALL contain the word array: synchronous write port, combinational read port.

Verification
REQ-038 Load mem[0..3]={0x20010005,0x20020007,0x00221820,0xFC000000}, start -> out_instruccion sequence matches words, out_pc_branch 4,8,12,16, then out_halted=1, PC=12 frozen.
REQ-039 RUN at PC=8, flag_branch=1 target 0x40 with flag_jump=1 target 0x80 -> PC=0x40, out_instruccion=0 next cycle.
REQ-040 stall=1 for 3 cycles at PC=4 -> PC, outputs unchanged; stall=1 with flag_jump_register target 0x10 -> PC=0x10, NOP emitted.
REQ-041 mem_depth=256, PC=0x3FC -> next fetch reads mem[0] (PC 0x400 wraps index).
REQ-042 reset=0 asserted between edges mid-RUN -> outputs 0 immediately; after start, mem contents still fetched unchanged.
REQ-043 load_enable=1 during RUN to addr 0 -> mem[0] unchanged on later reload fetch.
